ray_point_add: RTL and testbench

//  Downstream companion of vector_mul: completes the ray-point evaluation p = o + d*t.

---
 rtl/ray_point_add_pkg.sv | 12 +
 rtl/fixed_add_sat.sv | 16 +
 rtl/ray_point_add.sv | 71 +++++++
 tb/tb_ray_point_add.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ray_point_add_pkg.sv
// ray_point_add_pkg: shared Q16.16 vector widths, limits and types for the ray-point adder
package ray_point_add_pkg;
    localparam int FX_W = 32;
    localparam int FX_FRAC = 16;
    localparam int NUM_COMP = 3;
    localparam int VEC_W = FX_W * NUM_COMP;
    localparam logic [FX_W-1:0] FX_MAX = 32'h7FFFFFFF;
    localparam logic [FX_W-1:0] FX_MIN = 32'h80000000;
    localparam int MUL_LATENCY = 7;
    typedef logic [FX_W-1:0] fx_t;
    typedef logic [VEC_W-1:0] vec_t;
endpackage

// File: rtl/fixed_add_sat.sv
// fixed_add_sat: combinational Q16.16 adder with signed overflow detect and optional clamp
module fixed_add_sat
    import ray_point_add_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  fx_t  a,
    input  fx_t  b,
    output fx_t  r,
    output logic ovf
);
    fx_t s;
    assign s = a + b;
    assign ovf = (a[FX_W-1] == b[FX_W-1]) && (s[FX_W-1] != a[FX_W-1]);
    assign r = (SATURATE && ovf) ? (a[FX_W-1] ? FX_MIN : FX_MAX) : s;
endmodule

// File: rtl/ray_point_add.sv
// ray_point_add: queues ray origins and emits registered saturating o + d*t per returning product
module ray_point_add
    import ray_point_add_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue,
    input  logic [VEC_W-1:0]             issue_o,
    input  logic                         mul_valid,
    input  logic [VEC_W-1:0]             mul_r,
    output logic                         out_valid,
    output logic [VEC_W-1:0]             out_p,
    output logic [NUM_COMP-1:0]          sat,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         err_overflow,
    output logic                         err_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    if (DEPTH < MUL_LATENCY + 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("DEPTH must be a power of 2 and at least MUL_LATENCY+1");
    end
    vec_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic empty, full, do_push, do_pop;
    vec_t head, sum;
    logic [NUM_COMP-1:0] ovf;
    assign empty = level == '0;
    assign full = level == LW'(DEPTH);
    // an empty queue never bypasses: a pop with nothing queued is an underflow
    assign do_pop = mul_valid && !empty;
    assign do_push = issue && (!full || do_pop);
    assign head = mem[rptr];
    for (genvar i = 0; i < NUM_COMP; i++) begin : g_add
        fixed_add_sat #(.SATURATE(SATURATE)) u_add (
            .a  (head[FX_W*i +: FX_W]),
            .b  (mul_r[FX_W*i +: FX_W]),
            .r  (sum[FX_W*i +: FX_W]),
            .ovf(ovf[i])
        );
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= issue_o;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            out_valid <= 1'b0;
            out_p <= '0;
            sat <= '0;
            err_overflow <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            wptr <= wptr + AW'(do_push);
            rptr <= rptr + AW'(do_pop);
            level <= level + LW'(do_push) - LW'(do_pop);
            out_valid <= do_pop;
            if (do_pop) begin
                out_p <= sum;
                sat <= ovf;
            end
            if (issue && !do_push) err_overflow <= 1'b1;
            if (mul_valid && empty) err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ray_point_add.sv
// tb_ray_point_add: vector table, directed corner sequences and random scoreboard for ray_point_add
module tb_ray_point_add;
    logic clk = 1'b0, rst = 1'b1, issue = 1'b0, mul_valid = 1'b0;
    logic [95:0] issue_o = '0, mul_r = '0;
    logic out_valid, out_valid_w, err_overflow, err_overflow_w, err_underflow, err_underflow_w;
    logic [95:0] out_p, out_p_w;
    logic [2:0] sat, sat_w;
    logic [3:0] level, level_w;
    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    ray_point_add #(.DEPTH(8), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .issue(issue), .issue_o(issue_o), .mul_valid(mul_valid), .mul_r(mul_r),
        .out_valid(out_valid), .out_p(out_p), .sat(sat), .level(level),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );
    ray_point_add #(.DEPTH(8), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .issue(issue), .issue_o(issue_o), .mul_valid(mul_valid), .mul_r(mul_r),
        .out_valid(out_valid_w), .out_p(out_p_w), .sat(sat_w), .level(level_w),
        .err_overflow(err_overflow_w), .err_underflow(err_underflow_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference: widen to 64-bit integers, detect range escape, clamp or truncate
    function automatic logic [98:0] ref_vec(input logic [95:0] o, input logic [95:0] r, input bit satm);
        logic [98:0] res;
        longint s;
        for (int i = 0; i < 3; i++) begin
            s = longint'($signed(o[32*i +: 32])) + longint'($signed(r[32*i +: 32]));
            res[96+i] = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
            res[32*i +: 32] = (res[96+i] && satm) ? (s > 0 ? 32'h7FFFFFFF : 32'h80000000) : s[31:0];
        end
        return res;
    endfunction

    logic [95:0] q[$];
    logic [95:0] e_p = '0, e_pw = '0;
    logic [2:0] e_sat = '0, e_satw = '0;
    bit e_valid = 0, e_ovf = 0, e_unf = 0, m_pop;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            e_valid = 0; e_p = '0; e_pw = '0; e_sat = '0; e_satw = '0; e_ovf = 0; e_unf = 0;
        end else begin
            m_pop = mul_valid && (q.size() != 0);
            if (mul_valid && q.size() == 0) e_unf = 1;
            e_valid = m_pop;
            if (m_pop) begin
                {e_sat, e_p} = ref_vec(q[0], mul_r, 1'b1);
                {e_satw, e_pw} = ref_vec(q[0], mul_r, 1'b0);
                void'(q.pop_front());
            end
            if (issue) begin
                if (q.size() < 8) q.push_back(issue_o);
                else e_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sb_valid", 96'(out_valid), 96'(e_valid));
            check("sb_level", 96'(level), 96'(q.size()));
            check("sb_err_ovf", 96'(err_overflow), 96'(e_ovf));
            check("sb_err_unf", 96'(err_underflow), 96'(e_unf));
            check("sb_out_p", out_p, e_p);
            check("sb_sat", 96'(sat), 96'(e_sat));
            check("sb_valid_wrap", 96'(out_valid_w), 96'(e_valid));
            check("sb_out_p_wrap", out_p_w, e_pw);
            check("sb_sat_wrap", 96'(sat_w), 96'(e_satw));
        end
    end

    task automatic cyc(input bit i, input logic [95:0] o, input bit mv, input logic [95:0] r);
        issue = i; issue_o = o; mul_valid = mv; mul_r = r;
        @(posedge clk);
        #1;
        issue = 0; mul_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        cyc(0, '0, 0, '0);
        rst = 0;
    endtask

    function automatic logic [95:0] ov(input int k);
        return {32'h30000000 + 32'(k), 32'h20000000 + 32'(k), 32'h10000000 + 32'(k)};
    endfunction

    function automatic logic [31:0] rnd_comp();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'h7FFF0000 | ($urandom & 32'h0000FFFF);
            2: return 32'h80000000 | ($urandom & 32'h0000FFFF);
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    typedef struct {
        logic [95:0] o, r, ps, pw;
        logic [2:0] s;
    } vector_t;
    vector_t vecs[5];
    localparam logic [95:0] O1 = {32'hFFFD0000, 32'h00020000, 32'h00010000};
    localparam logic [95:0] R1 = {3{32'h00008000}};
    localparam logic [95:0] P1 = {32'hFFFD8000, 32'h00028000, 32'h00018000};

    initial begin
        int peak, nres;
        vecs[0] = '{O1, R1, P1, P1, 3'b000};
        vecs[1] = '{{64'h0, 32'h7FFF0000}, {64'h0, 32'h00020000}, {64'h0, 32'h7FFFFFFF}, {64'h0, 32'h80010000}, 3'b001};
        vecs[2] = '{{32'h0, 32'h80010000, 32'h0}, {32'h0, 32'hFFFE0000, 32'h0},
                    {32'h0, 32'h80000000, 32'h0}, {32'h0, 32'h7FFF0000, 32'h0}, 3'b010};
        vecs[3] = '{{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000}, {32'h00000001, 32'h80000000, 32'h80000000},
                    {32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000}, {32'h80000000, 32'hFFFFFFFF, 32'h00000000}, 3'b101};
        vecs[4] = '{{32'hC0000000, 32'h40000000, 32'hFFFF0000}, {32'hC0000000, 32'h3FFFFFFF, 32'h00010000},
                    {32'h80000000, 32'h7FFFFFFF, 32'h00000000}, {32'h80000000, 32'h7FFFFFFF, 32'h00000000}, 3'b000};

        do_reset();
        chk_en = 1;
        check("rst_valid", 96'(out_valid), 96'(0));
        check("rst_out_p", out_p, '0);
        check("rst_sat", 96'(sat), 96'(0));
        check("rst_level", 96'(level), 96'(0));
        check("rst_errs", 96'({err_overflow, err_underflow}), 96'(0));

        for (int v = 0; v < 5; v++) begin
            cyc(1, vecs[v].o, 0, '0);
            cyc(0, '0, 1, vecs[v].r);
            check($sformatf("vec%0d_valid", v), 96'(out_valid), 96'(1));
            check($sformatf("vec%0d_out_p", v), out_p, vecs[v].ps);
            check($sformatf("vec%0d_out_p_wrap", v), out_p_w, vecs[v].pw);
            check($sformatf("vec%0d_sat", v), 96'(sat), 96'(vecs[v].s));
            check($sformatf("vec%0d_sat_wrap", v), 96'(sat_w), 96'(vecs[v].s));
        end

        do_reset();
        cyc(1, O1, 0, '0);
        repeat (6) cyc(0, '0, 0, '0);
        cyc(0, '0, 1, R1);
        check("single_valid", 96'(out_valid), 96'(1));
        check("single_out_p", out_p, P1);
        check("single_sat", 96'(sat), 96'(0));
        check("single_level", 96'(level), 96'(0));

        do_reset();
        peak = 0; nres = 0;
        for (int c = 0; c < 27; c++) begin
            cyc(c < 20, ov(c + 100), c >= 7, {rnd_comp(), rnd_comp(), rnd_comp()});
            if (int'(level) > peak) peak = int'(level);
            if (out_valid) nres++;
        end
        check("stream_peak", 96'(peak), 96'(7));
        check("stream_results", 96'(nres), 96'(20));
        check("stream_errs", 96'({err_overflow, err_underflow}), 96'(0));

        do_reset();
        for (int k = 0; k < 8; k++) cyc(1, ov(k), 0, '0);
        check("full_level", 96'(level), 96'(8));
        check("full_no_err", 96'(err_overflow), 96'(0));
        cyc(1, ov(8), 0, '0);
        check("full_ovf", 96'(err_overflow), 96'(1));
        check("full_level_drop", 96'(level), 96'(8));
        cyc(1, ov(9), 1, '0);
        check("full_pushpop_p", out_p, ov(0));
        check("full_pushpop_level", 96'(level), 96'(8));
        for (int k = 1; k <= 8; k++) begin
            cyc(0, '0, 1, '0);
            check($sformatf("full_drain%0d", k), out_p, k < 8 ? ov(k) : ov(9));
        end
        check("full_drained", 96'(level), 96'(0));
        check("full_no_unf", 96'(err_underflow), 96'(0));

        do_reset();
        cyc(0, '0, 1, R1);
        check("unf_valid", 96'(out_valid), 96'(0));
        check("unf_flag", 96'(err_underflow), 96'(1));
        repeat (3) cyc(0, '0, 0, '0);
        check("unf_sticky", 96'(err_underflow), 96'(1));
        do_reset();
        check("unf_cleared", 96'(err_underflow), 96'(0));

        for (int k = 0; k < 3; k++) cyc(1, ov(k), 0, '0);
        do_reset();
        check("midrst_level", 96'(level), 96'(0));
        check("midrst_out", {out_p[92:0], out_valid, sat[1:0]}, '0);
        check("midrst_sat2", 96'({out_p[95:93], sat[2]}), 96'(0));
        cyc(1, O1, 0, '0);
        cyc(0, '0, 1, R1);
        check("midrst_fresh_p", out_p, P1);

        do_reset();
        repeat (400) cyc($urandom_range(0, 1) == 1, {rnd_comp(), rnd_comp(), rnd_comp()},
                         $urandom_range(0, 1) == 1, {rnd_comp(), rnd_comp(), rnd_comp()});
        repeat (2) cyc(0, '0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
